tsc_capture_ctrl: RTL and testbench
===================================

Name: tsc_capture_ctrl

Overview:
- Transient-capture controller that sequences the 8-bit ADC through its req/rdy handshake.
- Stores every conversion in a circular pre-trigger buffer and detects a threshold crossing.
- After the crossing, collects a fixed number of post-trigger samples, then streams the captured window out oldest-first over a valid/ready port.
- Sits between the ADC model and the downstream TSC consumer.

Parameters:
- BUF_AW, 4, buffer address width; buffer depth DEPTH = 2**BUF_AW (16).
- POST, 4, number of samples captured after the trigger sample (1..DEPTH-1).
- ADC_LAT, 2, minimum clocks from adc_req rise to sampling adc_dat.
- ADC_TMO, 15, clocks waited for adc_rdy after ADC_LAT before timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a capture; ignored unless idle.
- abort  in  1  returns to IDLE next cycle; wins over all other events.
- trig_thr  in  8  unsigned trigger threshold; sampled at start.
- adc_req  out  1  conversion request to the ADC.
- adc_rst  out  1  active-high reset to the ADC.
- adc_rdy  in  1  ADC ready level.
- adc_dat  in  8  ADC sample.
- busy  out  1  high in every state except IDLE.
- triggered  out  1  set at the trigger sample; cleared at start or reset.
- timeout_err  out  1  sticky; set on ADC timeout; cleared at start or reset.
- out_valid  out  1  stream data valid.
- out_data  out  8  stream sample.
- out_last  out  1  high with the final stream sample.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0. Pointers, sample count and latched threshold cleared. Buffer contents don't-care.
- States: IDLE, ARST, REQ, WAIT, CHECK, POSTC, DUMP.
- IDLE: on start, latch trig_thr, clear triggered/timeout_err/pointers/count, go to ARST.
- ARST: adc_rst=1 for exactly one cycle, resets the ADC sample index. Go to REQ.
- REQ: adc_req=1 for exactly one cycle (rising edge produces one conversion). Load the wait counter. Go to WAIT.
- WAIT: adc_req=0. Sample only when ≥ADC_LAT cycles have elapsed and adc_rdy=1.
  - adc_rdy may remain high across conversions; the controller relies on elapsed cycles, never on adc_rdy falling.
  - On sample: write adc_dat to buf[wr_ptr]; wr_ptr wraps modulo DEPTH; count saturates at DEPTH.
  - If ADC_LAT+ADC_TMO cycles elapse without a sample: set timeout_err and go to IDLE (no dump).
- CHECK, pre-trigger phase: if sample > latched threshold (strict, unsigned), set triggered, load post counter = POST, go to REQ. Otherwise go to REQ (continuous capture, oldest overwritten).
- POSTC, post-trigger phase: each stored sample decrements the post counter. At zero go to DUMP. rd_ptr = (count==DEPTH) ? wr_ptr : 0. Dump length = count.
- DUMP:
  - out_valid=1 with out_data=buf[rd_ptr].
  - Advance only when out_valid & out_ready.
  - out_data/out_last stable while stalled.
  - out_last=1 on the final entry. After its handshake, go to IDLE.
  - Sample-to-output read is combinational or registered, but out_valid must not assert before data is correct.
- Minimum per-sample period is ADC_LAT+2 clocks (REQ + WAIT + CHECK).
- Simultaneous start and abort: abort wins, stay IDLE.
- start while busy: ignored.
- abort: adc_req/out_valid drop next cycle; triggered/timeout_err retained.
- Mid-operation reset: immediate return to reset values. No partial stream continues.

Test Plan:
- ADC sequence 8B,8C,99,9B,93,82,97,90,9F,D7,8D,9C,85,8A, trig_thr=C0, defaults, out_ready=1 → triggered rises on sample D7 (index 9). 14 samples streamed 8B..8A in order; out_last only with 8A; busy falls after.
- Same, trig_thr=80, BUF_AW=2, POST=2 → trigger on 8B. Stream 8B,8C,99 (count 3<4, rd_ptr=0).
- trig_thr=D0, BUF_AW=2, POST=3 → trigger at D7, buffer wrapped. Stream 90,9F,D7,8D … wait count=DEPTH, so stream is the last 4 stored samples oldest-first: D7,8D,9C,85.
- Random out_ready (50%) during DUMP → no sample lost or duplicated; out_data stable whenever out_valid & !out_ready.
- adc_rdy held 0 after a request → timeout_err=1 after ADC_LAT+ADC_TMO clocks; state IDLE; out_valid never asserts.
- Assert abort during POSTC, then rst=0 mid-DUMP of a second run → adc_req and out_valid drop as specified; all outputs 0 during reset; a new start after release produces a full correct capture.

Source files
------------

// File: rtl/tsc_capture_ctrl_if.sv
// ADC handshake and output stream of the transient-capture controller.
// The master side is the controller; the slave side is the ADC plus the downstream consumer.
interface tsc_capture_ctrl_if;
  logic       adc_req;
  logic       adc_rst;
  logic       adc_rdy;
  logic [7:0] adc_dat;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output adc_req, adc_rst, out_valid, out_data, out_last,
    input  adc_rdy, adc_dat, out_ready
  );
  modport slave (
    input  adc_req, adc_rst, out_valid, out_data, out_last,
    output adc_rdy, adc_dat, out_ready
  );
endinterface

// File: rtl/tsc_capture_ctrl.sv
// Transient capture: keeps a circular pre-trigger buffer of ADC samples, waits for a threshold
// crossing, collects POST more samples, then streams the window out oldest-first.
module tsc_capture_ctrl #(
  parameter int BUF_AW  = 4,
  parameter int POST    = 4,
  parameter int ADC_LAT = 2,
  parameter int ADC_TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] trig_thr,
  output logic       busy,
  output logic       triggered,
  output logic       timeout_err,
  tsc_capture_ctrl_if.master bus
);
  localparam int DEPTH = 2**BUF_AW;
  localparam int WW    = $clog2(ADC_LAT + ADC_TMO + 1);
  localparam logic [WW-1:0]     LAT_C  = WW'(ADC_LAT);
  localparam logic [WW-1:0]     LIM_C  = WW'(ADC_LAT + ADC_TMO);
  localparam logic [BUF_AW:0]   FULL_C = (BUF_AW+1)'(DEPTH);
  localparam logic [BUF_AW-1:0] POST_C = BUF_AW'(POST);

  typedef enum logic [2:0] {IDLE, ARST, REQ, WAIT, CHECK, POSTC, DUMP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         thr_q, thr_d, smp_q, smp_d;
  logic               trig_q, trig_d, tmo_q, tmo_d;
  logic [BUF_AW-1:0]  wr_q, wr_d, rd_q, rd_d, post_q, post_d;
  logic [BUF_AW:0]    cnt_q, cnt_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic               we;
  logic [7:0]         mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      thr_q   <= '0;
      smp_q   <= '0;
      trig_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      post_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      smp_q   <= smp_d;
      trig_q  <= trig_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      post_q  <= post_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q] <= bus.adc_dat;
  end

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    smp_d   = smp_q;
    trig_d  = trig_q;
    tmo_d   = tmo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    post_d  = post_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    we      = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          thr_d   = trig_thr;
          trig_d  = 1'b0;
          tmo_d   = 1'b0;
          wr_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
          state_d = ARST;
        end
        ARST: state_d = REQ;
        REQ: begin
          wait_d  = WW'(1);
          state_d = WAIT;
        end
        // wait_q counts clocks since the request edge; adc_rdy may already be high from the
        // previous conversion, so the latency floor is what guards against stale data.
        WAIT: begin
          if (wait_q >= LAT_C && bus.adc_rdy) begin
            we      = 1'b1;
            smp_d   = bus.adc_dat;
            wr_d    = wr_q + BUF_AW'(1);
            if (cnt_q != FULL_C) cnt_d = cnt_q + (BUF_AW+1)'(1);
            state_d = trig_q ? POSTC : CHECK;
          end else if (wait_q >= LIM_C) begin
            tmo_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wait_d  = wait_q + WW'(1);
          end
        end
        CHECK: begin
          if (smp_q > thr_q) begin
            trig_d = 1'b1;
            post_d = POST_C;
          end
          state_d = REQ;
        end
        POSTC: begin
          post_d = post_q - BUF_AW'(1);
          if (post_q == BUF_AW'(1)) begin
            rd_d    = (cnt_q == FULL_C) ? wr_q : '0;
            state_d = DUMP;
          end else begin
            state_d = REQ;
          end
        end
        DUMP: if (bus.out_ready) begin
          if (cnt_q == (BUF_AW+1)'(1)) begin
            state_d = IDLE;
          end else begin
            rd_d  = rd_q + BUF_AW'(1);
            cnt_d = cnt_q - (BUF_AW+1)'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign triggered     = trig_q;
  assign timeout_err   = tmo_q;
  assign bus.adc_rst   = (state_q == ARST);
  assign bus.adc_req   = (state_q == REQ);
  assign bus.out_valid = (state_q == DUMP);
  assign bus.out_last  = (state_q == DUMP) && (cnt_q == (BUF_AW+1)'(1));
  assign bus.out_data  = (state_q == DUMP) ? mem_q[rd_q] : 8'h00;
endmodule

// File: tb/tb_tsc_capture_ctrl.sv
// Bench for tsc_capture_ctrl: three parameterisations share one ADC sample script; a window model
// predicts each capture and a per-cycle compare process checks the stream and reset outputs.
module tb_tsc_capture_ctrl;
  localparam int ADC_LAT = 2;
  localparam int ADC_TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] seq [16] = '{8'h8B, 8'h8C, 8'h99, 8'h9B, 8'h93, 8'h82, 8'h97, 8'h90,
                           8'h9F, 8'hD7, 8'h8D, 8'h9C, 8'h85, 8'h8A, 8'h00, 8'h00};

  logic [2:0] start_a = '0, abort_a = '0, busy_a, trig_a, tmo_a;
  logic [7:0] thr_a [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] ordy, rnd_mode, ov, ol, areq, arst;
  logic [7:0] od [3];
  logic       rdy_en0;

  tsc_capture_ctrl_if if0 ();
  tsc_capture_ctrl_if if1 ();
  tsc_capture_ctrl_if if2 ();

  tsc_capture_ctrl u0 (.clk(clk), .rst(rst_n), .start(start_a[0]), .abort(abort_a[0]),
    .trig_thr(thr_a[0]), .busy(busy_a[0]), .triggered(trig_a[0]), .timeout_err(tmo_a[0]), .bus(if0));
  tsc_capture_ctrl #(.BUF_AW(2), .POST(2)) u1 (.clk(clk), .rst(rst_n), .start(start_a[1]),
    .abort(abort_a[1]), .trig_thr(thr_a[1]), .busy(busy_a[1]), .triggered(trig_a[1]),
    .timeout_err(tmo_a[1]), .bus(if1));
  tsc_capture_ctrl #(.BUF_AW(2), .POST(3)) u2 (.clk(clk), .rst(rst_n), .start(start_a[2]),
    .abort(abort_a[2]), .trig_thr(thr_a[2]), .busy(busy_a[2]), .triggered(trig_a[2]),
    .timeout_err(tmo_a[2]), .bus(if2));

  assign if0.adc_rdy = rdy_en0;
  assign if1.adc_rdy = 1'b1;
  assign if2.adc_rdy = 1'b1;
  assign if0.out_ready = ordy[0];
  assign if1.out_ready = ordy[1];
  assign if2.out_ready = ordy[2];
  assign ov   = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign ol   = {if2.out_last,  if1.out_last,  if0.out_last};
  assign areq = {if2.adc_req,   if1.adc_req,   if0.adc_req};
  assign arst = {if2.adc_rst,   if1.adc_rst,   if0.adc_rst};
  assign od[0] = if0.out_data;
  assign od[1] = if1.out_data;
  assign od[2] = if2.out_data;

  // ADC model: each request edge converts the next scripted sample; adc_rst rewinds the script.
  int a0 = 0, a1 = 0, a2 = 0;
  always @(posedge clk) begin
    if (if0.adc_rst) a0 <= 0;
    else if (if0.adc_req) begin if0.adc_dat <= seq[a0[3:0]]; a0 <= a0 + 1; end
  end
  always @(posedge clk) begin
    if (if1.adc_rst) a1 <= 0;
    else if (if1.adc_req) begin if1.adc_dat <= seq[a1[3:0]]; a1 <= a1 + 1; end
  end
  always @(posedge clk) begin
    if (if2.adc_rst) a2 <= 0;
    else if (if2.adc_req) begin if2.adc_dat <= seq[a2[3:0]]; a2 <= a2 + 1; end
  end

  function automatic int aidx(input int k);
    case (k)
      0:       return a0;
      1:       return a1;
      default: return a2;
    endcase
  endfunction

  int nvec = 0, nerr = 0;
  int exp_len [3] = '{0, 0, 0};
  int exp_pos [3] = '{0, 0, 0};
  int trig_idx [3] = '{0, 0, 0};
  int trig_at [3] = '{-1, -1, -1};
  logic [7:0] exp_mem [3][16];
  logic [2:0] stall = '0, tprev = '0, sl = '0;
  logic [7:0] sd [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Window model: first sample above threshold triggers, POST more follow, and the stream is
  // the most recent min(total, DEPTH) samples in arrival order.
  task automatic build(input int k, input logic [7:0] thr);
    int depth, post, ti, n, m;
    depth = (k == 0) ? 16 : 4;
    post  = (k == 0) ? 4 : (k == 1) ? 2 : 3;
    ti = -1;
    for (int i = 0; i < 14; i++) if (ti < 0 && seq[i] > thr) ti = i;
    n = ti + post + 1;
    m = (n < depth) ? n : depth;
    for (int i = 0; i < m; i++) exp_mem[k][i] = seq[n - m + i];
    exp_len[k] = m;
    exp_pos[k] = 0;
    trig_idx[k] = ti;
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk("reset_outputs", {busy_a[k], trig_a[k], tmo_a[k], areq[k], arst[k], ov[k], ol[k], od[k]}, 0);
        stall[k] = 1'b0;
        tprev[k] = 1'b0;
      end else begin
        if (trig_a[k] && !tprev[k]) trig_at[k] = aidx(k);
        tprev[k] = trig_a[k];
        if (stall[k]) chk("stall_hold", {ov[k], ol[k], od[k]}, {1'b1, sl[k], sd[k]});
        if (ov[k]) begin
          if (exp_pos[k] >= exp_len[k]) chk("unexpected_valid", ov[k], 0);
          else if (ordy[k]) begin
            chk("out_data", od[k], exp_mem[k][exp_pos[k]]);
            chk("out_last", ol[k], exp_pos[k] == exp_len[k] - 1);
            exp_pos[k]++;
          end
        end
        stall[k] = ov[k] && !ordy[k];
        sl[k] = ol[k];
        sd[k] = od[k];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [7:0] thr, input logic ab);
    step();
    start_a[k] = 1'b1;
    abort_a[k] = ab;
    thr_a[k] = thr;
    step();
    start_a[k] = 1'b0;
    abort_a[k] = 1'b0;
  endtask

  task automatic run(input int k, input logic [7:0] thr, input logic rnd,
                     input int lit_len, input logic [7:0] lit_first, input int lit_ti);
    int cyc;
    build(k, thr);
    chk("model_len", exp_len[k], lit_len);
    chk("model_first", exp_mem[k][0], lit_first);
    chk("model_trig", trig_idx[k], lit_ti);
    rnd_mode[k] = rnd;
    trig_at[k] = -1;
    pulse(k, thr, 1'b0);
    chk("busy_on", busy_a[k], 1);
    cyc = 0;
    while (busy_a[k] && cyc < 2000) begin step(); cyc++; end
    chk("done_in_time", cyc < 2000, 1);
    chk("stream_count", exp_pos[k], exp_len[k]);
    chk("trig_sample", trig_at[k], trig_idx[k] + 1);
    chk("triggered", trig_a[k], 1);
    chk("timeout_clear", tmo_a[k], 0);
    rnd_mode[k] = 1'b0;
  endtask

  initial begin
    int cyc;
    ordy = 3'b111;
    rnd_mode = '0;
    rdy_en0 = 1'b1;
    fork
      forever begin @(negedge clk); cmp_all(); end
      forever begin
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) ordy[k] = rnd_mode[k] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    repeat (3) step();
    chk("reset_busy", busy_a, 0);
    rst_n = 1'b1;
    step();

    run(0, 8'hC0, 1'b0, 14, 8'h8B, 9);
    run(1, 8'h80, 1'b0, 3, 8'h8B, 0);
    run(2, 8'hD0, 1'b0, 4, 8'hD7, 9);
    run(0, 8'hC0, 1'b1, 14, 8'h8B, 9);

    // start and abort together: must stay idle
    pulse(0, 8'hC0, 1'b1);
    chk("start_abort_idle", busy_a[0], 0);

    // ADC never ready: timeout after the full wait window, no dump
    exp_len[0] = 0; exp_pos[0] = 0;
    rdy_en0 = 1'b0;
    pulse(0, 8'hC0, 1'b0);
    cyc = 0;
    while (!areq[0] && cyc < 20) begin step(); cyc++; end
    chk("req_seen", areq[0], 1);
    cyc = 0;
    while (!tmo_a[0] && cyc < 100) begin step(); cyc++; end
    chk("timeout_latency", cyc, ADC_LAT + ADC_TMO + 1);
    chk("timeout_idle", busy_a[0], 0);
    rdy_en0 = 1'b1;

    // abort in the post-trigger phase
    pulse(0, 8'hC0, 1'b0);
    chk("timeout_cleared", tmo_a[0], 0);
    cyc = 0;
    while (!trig_a[0] && cyc < 300) begin step(); cyc++; end
    chk("trig_before_abort", trig_a[0], 1);
    step(); step();
    abort_a[0] = 1'b1;
    step();
    abort_a[0] = 1'b0;
    chk("abort_req", areq[0], 0);
    chk("abort_busy", busy_a[0], 0);
    chk("abort_valid", ov[0], 0);
    chk("abort_keeps_trig", trig_a[0], 1);

    // reset in the middle of a stalled dump
    build(0, 8'hC0);
    rnd_mode[0] = 1'b1;
    pulse(0, 8'hC0, 1'b0);
    cyc = 0;
    while (exp_pos[0] < 3 && cyc < 1000) begin step(); cyc++; end
    chk("dump_progress", exp_pos[0] >= 3, 1);
    exp_len[0] = 0;
    rst_n = 1'b0;
    repeat (3) step();
    chk("mid_reset_busy", busy_a, 0);
    rst_n = 1'b1;
    rnd_mode[0] = 1'b0;
    step();

    run(0, 8'hC0, 1'b1, 14, 8'h8B, 9);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
